// File: rtl/afifo_rd_ctrl.sv
// Read-domain half of an asynchronous FIFO: write-pointer synchronizer, read pointers,
// empty/almost-empty/fill flags and a one-entry valid/ready output register.
module afifo_rd_ctrl #(
    parameter int DATASIZE  = 8,
    parameter int ADDRSIZE  = 4,
    parameter int AEMPTY_TH = 1
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rfill,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATASIZE-1:0] rdata
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0]       rbin_reg;
    logic [PW-1:0]       rptr_reg;
    logic [PW-1:0]       rq1_wptr_reg;
    logic [PW-1:0]       rq2_wptr_reg;
    logic [PW-1:0]       rfill_reg;
    logic                rempty_reg;
    logic                raempty_reg;
    logic                rvalid_reg;
    logic [DATASIZE-1:0] rdata_reg;

    logic                pop;
    logic [PW-1:0]       rbin_next;
    logic [PW-1:0]       rgray_next;
    logic [PW-1:0]       wbin_s;
    logic [PW-1:0]       rfill_next;
    logic                rempty_next;
    logic                raempty_next;
    logic                rvalid_next;
    logic [DATASIZE-1:0] rdata_next;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign wbin_s[gi] = ^rq2_wptr_reg[PW-1:gi];
        end
    endgenerate

    always_comb begin
        pop          = !rempty_reg && (!rvalid_reg || rready);
        rbin_next    = rbin_reg + PW'(pop);
        rgray_next   = rbin_next ^ (rbin_next >> 1);
        // Modular difference naturally yields DEPTH when the pointers differ only in the MSB.
        rfill_next   = wbin_s - rbin_next;
        rempty_next  = (rgray_next == rq2_wptr_reg);
        raempty_next = (rfill_next <= PW'(AEMPTY_TH));
    end

    // The output register reloads on every pop, so a simultaneous drain and refill has no bubble.
    always_comb begin
        rvalid_next = rvalid_reg;
        rdata_next  = rdata_reg;
        if (pop) begin
            rvalid_next = 1'b1;
            rdata_next  = mem_rdata;
        end else if (rvalid_reg && rready) begin
            rvalid_next = 1'b0;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin_reg     <= '0;
            rptr_reg     <= '0;
            rq1_wptr_reg <= '0;
            rq2_wptr_reg <= '0;
            rfill_reg    <= '0;
            rempty_reg   <= 1'b1;
            raempty_reg  <= 1'b1;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            rq1_wptr_reg <= wptr;
            rq2_wptr_reg <= rq1_wptr_reg;
            rbin_reg     <= rbin_next;
            rptr_reg     <= rgray_next;
            rfill_reg    <= rfill_next;
            rempty_reg   <= rempty_next;
            raempty_reg  <= raempty_next;
            rvalid_reg   <= rvalid_next;
            rdata_reg    <= rdata_next;
        end
    end

    always_comb begin
        raddr   = rbin_reg[ADDRSIZE-1:0];
        rptr    = rptr_reg;
        rempty  = rempty_reg;
        raempty = raempty_reg;
        rfill   = rfill_reg;
        rvalid  = rvalid_reg;
        rdata   = rdata_reg;
    end

endmodule
